dac_threshold_spi: RTL and testbench

Serialises threshold codes from the channel measure controller to an external 16-bit SPI DAC that sets the comparator threshold.
- Accepts a one-cycle write strobe plus code and transmits a {command, code} frame.
- Waits a programmable analog settle time, then reasserts ready so the controller can sample the comparator.
- Sits directly downstream of the controller's threshold_o/threshold_wre_o outputs and drives its threshold_rdy_i input.

---
 rtl/dac_threshold_spi.sv | 144 ++++++++++++++
 tb/tb_dac_threshold_spi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_threshold_spi.sv
// dac_threshold_spi
//   Serialises comparator threshold codes to an external 16-bit SPI DAC.
//   An accepted write sends a 24-bit frame {CMD, code} MSB first. The
//   block then waits a fixed analog settle time before it reasserts ready.
//
// Ports
//   clk_i            system clock
//   arst_ni          asynchronous active-low reset
//   threshold_i      DAC code, sampled only on an accepted write
//   threshold_wre_i  write strobe, accepted while threshold_rdy_o=1
//   threshold_rdy_o  idle and settled; the next write is accepted
//   wr_drop_o        one-cycle pulse per strobe cycle discarded while busy
//   dac_cs_no        DAC chip select, active low
//   dac_sclk_o       SPI clock, idles low
//   dac_mosi_o       SPI data, MSB first, sampled by the DAC on SCLK rise
module dac_threshold_spi #(
  parameter int unsigned CLK_DIV       = 2,
  parameter logic [7:0]  CMD           = 8'h30,
  parameter int unsigned SETTLE_CYCLES = 100
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic [15:0] threshold_i,
  input  logic        threshold_wre_i,
  output logic        threshold_rdy_o,
  output logic        wr_drop_o,
  output logic        dac_cs_no,
  output logic        dac_sclk_o,
  output logic        dac_mosi_o
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [HW-1:0] HALF_LOAD   = HW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT    = 5'd23;

  logic [1:0]    r_state;
  logic [23:0]   r_shift;
  logic [4:0]    r_bit;
  logic [HW-1:0] r_half;
  logic [SW-1:0] r_settle;
  logic          r_rdy;
  logic          r_drop;
  logic          r_cs_n;
  logic          r_sclk;
  logic          r_mosi;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_half   <= '0;
      r_settle <= '0;
      r_rdy    <= 1'b1;
      r_drop   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else begin
      // Ready is high only in IDLE, so any strobe outside IDLE is a drop.
      r_drop <= threshold_wre_i && (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (threshold_wre_i) begin
            // The MSB goes straight to MOSI. The shift register keeps the
            // remaining 23 bits left-aligned, so bit 23 is always the next bit.
            r_shift <= {CMD[6:0], threshold_i, 1'b0};
            r_mosi  <= CMD[7];
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_rdy   <= 1'b0;
            r_half  <= HALF_LOAD;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_half != '0) begin
            r_half <= r_half - HW'(1);
          end else begin
            r_half <= HALF_LOAD;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == LAST_BIT) begin
                r_state <= S_HOLD;
              end else begin
                r_bit   <= r_bit + 5'd1;
                r_mosi  <= r_shift[23];
                r_shift <= {r_shift[22:0], 1'b0};
              end
            end
          end
        end

        S_HOLD: begin
          if (r_half != '0) begin
            r_half <= r_half - HW'(1);
          end else begin
            r_cs_n   <= 1'b1;
            r_mosi   <= 1'b0;
            r_settle <= SETTLE_LOAD;
            r_state  <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - SW'(1);
          end else begin
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b1;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign threshold_rdy_o = r_rdy;
  assign wr_drop_o       = r_drop;
  assign dac_cs_no       = r_cs_n;
  assign dac_sclk_o      = r_sclk;
  assign dac_mosi_o      = r_mosi;

endmodule

// File: tb/tb_dac_threshold_spi.sv
// tb_dac_threshold_spi
//   Directed bench for dac_threshold_spi. Instance 0 uses the defaults
//   (CLK_DIV=2, SETTLE_CYCLES=100). Instance 1 uses the fastest setting
//   (CLK_DIV=1, SETTLE_CYCLES=1). A negedge monitor reconstructs each SPI
//   frame from the pins. The scenario tasks compare these frames against
//   hand-computed values.
module tb_dac_threshold_spi;

  localparam int DIV0 = 2;
  localparam int SET0 = 100;
  localparam int DIV1 = 1;
  localparam int SET1 = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wre   = '0;
  logic [15:0] thr0  = '0;
  logic [15:0] thr1  = '0;
  logic [1:0]  rdy, drop, cs, sclk, mosi;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_threshold_spi #(.CLK_DIV(DIV0), .CMD(8'h30), .SETTLE_CYCLES(SET0)) u_dut0 (
    .clk_i(clk), .arst_ni(rst_n), .threshold_i(thr0), .threshold_wre_i(wre[0]),
    .threshold_rdy_o(rdy[0]), .wr_drop_o(drop[0]), .dac_cs_no(cs[0]),
    .dac_sclk_o(sclk[0]), .dac_mosi_o(mosi[0]));

  dac_threshold_spi #(.CLK_DIV(DIV1), .CMD(8'h30), .SETTLE_CYCLES(SET1)) u_dut1 (
    .clk_i(clk), .arst_ni(rst_n), .threshold_i(thr1), .threshold_wre_i(wre[1]),
    .threshold_rdy_o(rdy[1]), .wr_drop_o(drop[1]), .dac_cs_no(cs[1]),
    .dac_sclk_o(sclk[1]), .dac_mosi_o(mosi[1]));

  // Pin-level monitor; counters only grow, tests work on differences.
  logic [1:0]  prev_cs   = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;
  logic [23:0] cur_frame [2];
  int          cur_edges [2];
  int          last_rise [2];
  int          fcnt      [2];
  int          rdy_low   [2];
  int          drop_cyc  [2];
  int          bad_per   [2];
  int          stray     [2];
  int          fall_cyc  [2];
  logic [23:0] flog      [2][32];
  int          elog      [2][32];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (prev_cs[g] === 1'b1 && cs[g] === 1'b0) begin
        cur_frame[g] = '0;
        cur_edges[g] = 0;
        fall_cyc[g]  = cyc;
      end
      if (sclk[g] === 1'b1 && prev_sclk[g] === 1'b0) begin
        if (cs[g] === 1'b0) begin
          if (cur_edges[g] > 0 && (cyc - last_rise[g]) != 2 * (g == 0 ? DIV0 : DIV1))
            bad_per[g]++;
          last_rise[g] = cyc;
          cur_frame[g] = {cur_frame[g][22:0], mosi[g]};
          cur_edges[g]++;
        end else begin
          stray[g]++;
        end
      end
      if (prev_cs[g] === 1'b0 && cs[g] === 1'b1) begin
        flog[g][fcnt[g] % 32] = cur_frame[g];
        elog[g][fcnt[g] % 32] = cur_edges[g];
        fcnt[g]++;
      end
      if (rdy[g] !== 1'b1) rdy_low[g]++;
      if (drop[g] === 1'b1) drop_cyc[g]++;
      prev_cs[g]   = cs[g];
      prev_sclk[g] = sclk[g];
    end
  end

  task automatic do_write(input int g, input logic [15:0] code);
    @(negedge clk);
    if (g == 0) thr0 = code; else thr1 = code;
    wre[g] = 1'b1;
    @(negedge clk);
    wre[g] = 1'b0;
    if (g == 0) thr0 = ~code; else thr1 = ~code;
  endtask

  task automatic wait_rdy(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rdy[g] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (rdy[g] !== 1'b1) begin errors++; $display("FAIL reset_rdy[%0d] got %b exp 1", g, rdy[g]); end
      checks++; if (drop[g] !== 1'b0) begin errors++; $display("FAIL reset_drop[%0d] got %b exp 0", g, drop[g]); end
      checks++; if (cs[g] !== 1'b1) begin errors++; $display("FAIL reset_cs[%0d] got %b exp 1", g, cs[g]); end
      checks++; if (sclk[g] !== 1'b0) begin errors++; $display("FAIL reset_sclk[%0d] got %b exp 0", g, sclk[g]); end
      checks++; if (mosi[g] !== 1'b0) begin errors++; $display("FAIL reset_mosi[%0d] got %b exp 0", g, mosi[g]); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int fb, rb, db, bb, sb;
    bit ok;
    @(negedge clk); #1;
    fb = fcnt[0]; rb = rdy_low[0]; db = drop_cyc[0]; bb = bad_per[0]; sb = stray[0];
    do_write(0, 16'hA5C3);
    wait_rdy(0, ok); #1;
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got 0 exp 1"); end
    checks++; if (fcnt[0] - fb != 1) begin errors++; $display("FAIL basic_frames got %0d exp 1", fcnt[0] - fb); end
    checks++; if (flog[0][fb % 32] !== 24'h30A5C3) begin errors++; $display("FAIL basic_frame got %h exp 30a5c3", flog[0][fb % 32]); end
    checks++; if (elog[0][fb % 32] != 24) begin errors++; $display("FAIL basic_edges got %0d exp 24", elog[0][fb % 32]); end
    checks++; if (rdy_low[0] - rb != 198) begin errors++; $display("FAIL basic_rdy_low got %0d exp 198", rdy_low[0] - rb); end
    checks++; if (drop_cyc[0] - db != 0) begin errors++; $display("FAIL basic_drop got %0d exp 0", drop_cyc[0] - db); end
    checks++; if (bad_per[0] - bb != 0) begin errors++; $display("FAIL basic_sclk_period got %0d bad exp 0", bad_per[0] - bb); end
    checks++; if (stray[0] - sb != 0) begin errors++; $display("FAIL basic_stray_edges got %0d exp 0", stray[0] - sb); end
  endtask

  task automatic test_back_to_back;
    int fb, db, sc;
    bit ok1, ok2;
    @(negedge clk); #1;
    fb = fcnt[0]; db = drop_cyc[0];
    do_write(0, 16'h0000);
    wait_rdy(0, ok1);
    thr0   = 16'hFFFF;
    wre[0] = 1'b1;
    sc     = cyc;
    @(negedge clk);
    wre[0] = 1'b0;
    thr0   = 16'h0000;
    wait_rdy(0, ok2); #1;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout got %b%b exp 11", ok1, ok2); end
    checks++; if (fcnt[0] - fb != 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2", fcnt[0] - fb); end
    checks++; if (flog[0][fb % 32] !== 24'h300000) begin errors++; $display("FAIL b2b_frame0 got %h exp 300000", flog[0][fb % 32]); end
    checks++; if (flog[0][(fb + 1) % 32] !== 24'h30FFFF) begin errors++; $display("FAIL b2b_frame1 got %h exp 30ffff", flog[0][(fb + 1) % 32]); end
    checks++; if (fall_cyc[0] != sc + 1) begin errors++; $display("FAIL b2b_cs_fall got %0d exp %0d", fall_cyc[0], sc + 1); end
    checks++; if (drop_cyc[0] - db != 0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_cyc[0] - db); end
  endtask

  task automatic test_drop_busy;
    int fb, db, rb;
    bit ok;
    @(negedge clk); #1;
    fb = fcnt[0]; db = drop_cyc[0]; rb = rdy_low[0];
    do_write(0, 16'h5A5A);
    repeat (48) @(negedge clk);
    thr0   = 16'h1234;
    wre[0] = 1'b1;
    @(negedge clk);
    wre[0] = 1'b0;
    wait_rdy(0, ok);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got 0 exp 1"); end
    checks++; if (fcnt[0] - fb != 1) begin errors++; $display("FAIL drop_frames got %0d exp 1", fcnt[0] - fb); end
    checks++; if (flog[0][fb % 32] !== 24'h305A5A) begin errors++; $display("FAIL drop_frame got %h exp 305a5a", flog[0][fb % 32]); end
    checks++; if (drop_cyc[0] - db != 1) begin errors++; $display("FAIL drop_pulses got %0d exp 1", drop_cyc[0] - db); end
    checks++; if (rdy_low[0] - rb != 198) begin errors++; $display("FAIL drop_rdy_low got %0d exp 198", rdy_low[0] - rb); end
  endtask

  task automatic test_reset_mid;
    int fb, rb;
    bit found, ok;
    found = 1'b0;
    do_write(0, 16'hC0DE);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (cur_edges[0] == 10) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_bit10 got %0d exp 10", cur_edges[0]); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL rstmid_cs got %b exp 1", cs[0]); end
    checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b exp 0", sclk[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got %b exp 1", rdy[0]); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    fb = fcnt[0]; rb = rdy_low[0];
    do_write(0, 16'h0F0F);
    wait_rdy(0, ok); #1;
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got 0 exp 1"); end
    checks++; if (fcnt[0] - fb != 1) begin errors++; $display("FAIL rstmid_frames got %0d exp 1", fcnt[0] - fb); end
    checks++; if (flog[0][fb % 32] !== 24'h300F0F) begin errors++; $display("FAIL rstmid_frame got %h exp 300f0f", flog[0][fb % 32]); end
    checks++; if (elog[0][fb % 32] != 24) begin errors++; $display("FAIL rstmid_edges got %0d exp 24", elog[0][fb % 32]); end
    checks++; if (rdy_low[0] - rb != 198) begin errors++; $display("FAIL rstmid_rdy_low got %0d exp 198", rdy_low[0] - rb); end
  endtask

  task automatic test_fast;
    int fb, rb, bb;
    bit ok;
    @(negedge clk); #1;
    fb = fcnt[1]; rb = rdy_low[1]; bb = bad_per[1];
    do_write(1, 16'h8001);
    wait_rdy(1, ok); #1;
    checks++; if (!ok) begin errors++; $display("FAIL fast_timeout got 0 exp 1"); end
    checks++; if (fcnt[1] - fb != 1) begin errors++; $display("FAIL fast_frames got %0d exp 1", fcnt[1] - fb); end
    checks++; if (flog[1][fb % 32] !== 24'h308001) begin errors++; $display("FAIL fast_frame got %h exp 308001", flog[1][fb % 32]); end
    checks++; if (elog[1][fb % 32] != 24) begin errors++; $display("FAIL fast_edges got %0d exp 24", elog[1][fb % 32]); end
    checks++; if (rdy_low[1] - rb != 50) begin errors++; $display("FAIL fast_rdy_low got %0d exp 50", rdy_low[1] - rb); end
    checks++; if (bad_per[1] - bb != 0) begin errors++; $display("FAIL fast_sclk_period got %0d bad exp 0", bad_per[1] - bb); end
  endtask

  task automatic test_hold_strobe;
    int fb, db;
    bit ok;
    @(negedge clk); #1;
    fb = fcnt[0]; db = drop_cyc[0];
    @(negedge clk);
    thr0   = 16'h7E81;
    wre[0] = 1'b1;
    @(negedge clk);
    thr0   = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    wre[0] = 1'b0;
    wait_rdy(0, ok); #1;
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got 0 exp 1"); end
    checks++; if (fcnt[0] - fb != 1) begin errors++; $display("FAIL hold_frames got %0d exp 1", fcnt[0] - fb); end
    checks++; if (flog[0][fb % 32] !== 24'h307E81) begin errors++; $display("FAIL hold_frame got %h exp 307e81", flog[0][fb % 32]); end
    checks++; if (drop_cyc[0] - db != 2) begin errors++; $display("FAIL hold_drops got %0d exp 2", drop_cyc[0] - db); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_drop_busy;
    test_reset_mid;
    test_fast;
    test_hold_strobe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
